// File: rtl/rggen_mux_pipe.sv
// Two-stage pipelined one-hot AND-OR read-data mux with valid/ready flow control.
// Stage 1 reduces GROUP-sized slices; stage 2 merges the groups and derives hit flags.
module rggen_mux_pipe #(
    parameter int WIDTH    = 1,
    parameter int ENTRIES  = 2,
    parameter int GROUP    = 4,
    parameter int PRIORITY = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ENTRIES-1:0]         i_select,
    input  logic [WIDTH*ENTRIES-1:0]   i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_multi_hit,
    output logic                       o_no_hit
);

    localparam int NG = (ENTRIES + GROUP - 1) / GROUP;
    localparam int NP = NG * GROUP;

    logic                      s1_valid_q, s1_valid_d;
    logic [NG-1:0][WIDTH-1:0]  partial_q, partial_d;
    logic [NG-1:0]             any_q, any_d;
    logic [NG-1:0]             multi_q, multi_d;

    logic                      o_valid_q, o_valid_d;
    logic [WIDTH-1:0]          o_data_q, o_data_d;
    logic                      o_multi_hit_q, o_multi_hit_d;
    logic                      o_no_hit_q, o_no_hit_d;

    logic [ENTRIES-1:0]        sel_eff;
    logic [NP-1:0]             sel_raw_pad;
    logic [NP-1:0]             sel_eff_pad;
    logic [NP*WIDTH-1:0]       data_pad;

    logic [NG-1:0][WIDTH-1:0]  grp_partial;
    logic [NG-1:0]             grp_any;
    logic [NG-1:0]             grp_multi;

    logic [WIDTH-1:0]          red_data;
    logic                      red_across;
    logic                      red_seen;

    logic                      s2_adv;
    logic                      s1_adv;
    logic                      in_xfer;

    assign s2_adv  = ~o_valid_q | i_ready;
    assign s1_adv  = s1_valid_q & s2_adv;
    assign o_ready = ~s1_valid_q | s2_adv;
    assign in_xfer = i_valid & o_ready;

    // Padding the last group to a full GROUP keeps every slice index in range.
    always_comb begin
        if (PRIORITY != 0) begin
            sel_eff = i_select & (~i_select + ENTRIES'(1));
        end else begin
            sel_eff = i_select;
        end
        sel_raw_pad                      = '0;
        sel_raw_pad[ENTRIES-1:0]         = i_select;
        sel_eff_pad                      = '0;
        sel_eff_pad[ENTRIES-1:0]         = sel_eff;
        data_pad                         = '0;
        data_pad[ENTRIES*WIDTH-1:0]      = i_data;
    end

    always_comb begin
        grp_partial = '0;
        grp_any     = '0;
        grp_multi   = '0;
        for (int g = 0; g < NG; g++) begin
            for (int k = 0; k < GROUP; k++) begin
                if (sel_raw_pad[g*GROUP+k]) begin
                    grp_multi[g] = grp_multi[g] | grp_any[g];
                    grp_any[g]   = 1'b1;
                end
                grp_partial[g] = grp_partial[g]
                               | ({WIDTH{sel_eff_pad[g*GROUP+k]}}
                                  & data_pad[(g*GROUP+k)*WIDTH +: WIDTH]);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        partial_d  = partial_q;
        any_d      = any_q;
        multi_d    = multi_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            partial_d  = grp_partial;
            any_d      = grp_any;
            multi_d    = grp_multi;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // A hit in two different groups is a multi-hit even if each group saw only one bit.
    always_comb begin
        red_data   = '0;
        red_across = 1'b0;
        red_seen   = 1'b0;
        for (int g = 0; g < NG; g++) begin
            red_data = red_data | partial_q[g];
            if (any_q[g]) begin
                red_across = red_across | red_seen;
                red_seen   = 1'b1;
            end
        end
    end

    always_comb begin
        o_valid_d     = o_valid_q;
        o_data_d      = o_data_q;
        o_multi_hit_d = o_multi_hit_q;
        o_no_hit_d    = o_no_hit_q;
        if (s1_adv) begin
            o_valid_d     = 1'b1;
            o_data_d      = red_data;
            o_multi_hit_d = (|multi_q) | red_across;
            o_no_hit_d    = ~(|any_q);
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q    <= 1'b0;
            partial_q     <= '0;
            any_q         <= '0;
            multi_q       <= '0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_multi_hit_q <= 1'b0;
            o_no_hit_q    <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            partial_q     <= partial_d;
            any_q         <= any_d;
            multi_q       <= multi_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            o_multi_hit_q <= o_multi_hit_d;
            o_no_hit_q    <= o_no_hit_d;
        end
    end

    assign o_valid     = o_valid_q;
    assign o_data      = o_data_q;
    assign o_multi_hit = o_multi_hit_q;
    assign o_no_hit    = o_no_hit_q;

endmodule

// File: tb/tb_rggen_mux_pipe.sv
// Scoreboard bench for rggen_mux_pipe: OR mode and priority mode instances share stimulus.
module tb_rggen_mux_pipe;

    localparam int W = 8;
    localparam int E = 6;
    localparam int G = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         m;
        logic         n;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic [E-1:0]   i_select;
    logic [W*E-1:0] i_data;
    logic           i_ready;

    logic           o_ready0, o_valid0, o_multi0, o_nohit0;
    logic [W-1:0]   o_data0;
    logic           o_ready1, o_valid1, o_multi1, o_nohit1;
    logic [W-1:0]   o_data1;

    int n_cmp = 0;
    int n_err = 0;
    int pops0 = 0;
    int pops1 = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    rggen_mux_pipe #(.WIDTH(W), .ENTRIES(E), .GROUP(G), .PRIORITY(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready0),
        .i_select(i_select), .i_data(i_data), .o_valid(o_valid0), .i_ready(i_ready),
        .o_data(o_data0), .o_multi_hit(o_multi0), .o_no_hit(o_nohit0)
    );

    rggen_mux_pipe #(.WIDTH(W), .ENTRIES(E), .GROUP(G), .PRIORITY(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready1),
        .i_select(i_select), .i_data(i_data), .o_valid(o_valid1), .i_ready(i_ready),
        .o_data(o_data1), .o_multi_hit(o_multi1), .o_no_hit(o_nohit1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word i is 0x10+i; priority keeps the first set bit scanning upward.
    function automatic exp_t model(input logic [E-1:0] sel, input bit prio);
        exp_t r;
        int   hits;
        bit   taken;
        r     = '0;
        hits  = 0;
        taken = 0;
        for (int i = 0; i < E; i++) begin
            if (sel[i]) begin
                hits++;
                if (!prio || !taken) r.d = r.d | W'(8'h10 + i);
                taken = 1;
            end
        end
        r.m = (hits > 1);
        r.n = (hits == 0);
        return r;
    endfunction

    task automatic push_exp(input logic [E-1:0] sel);
        q0.push_back(model(sel, 1'b0));
        q1.push_back(model(sel, 1'b1));
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [E-1:0] sel);
        int t;
        t        = 0;
        i_valid  = 1'b1;
        i_select = sel;
        @(negedge clk);
        while (!o_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready0) check("send_timeout", 32'd0, 32'd1);
        else push_exp(sel);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_q0_empty", q0.size(), 0);
        check("drain_q1_empty", q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && i_ready) begin
            if (o_valid0) begin
                if (q0.size() == 0) begin
                    check("unexpected_out_or", {31'd0, o_valid0}, 32'd0);
                end else begin
                    e = q0.pop_front();
                    pops0++;
                    check("or_data", o_data0, e.d);
                    check("or_multi", o_multi0, e.m);
                    check("or_nohit", o_nohit0, e.n);
                end
            end
            if (o_valid1) begin
                if (q1.size() == 0) begin
                    check("unexpected_out_pri", {31'd0, o_valid1}, 32'd0);
                end else begin
                    e = q1.pop_front();
                    pops1++;
                    check("pri_data", o_data1, e.d);
                    check("pri_multi", o_multi1, e.m);
                    check("pri_nohit", o_nohit1, e.n);
                end
            end
        end
    end

    initial begin
        int base0;
        int base1;
        logic [E-1:0] s;

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_select = '0;
        i_ready  = 1'b1;
        for (int i = 0; i < E; i++) i_data[i*W +: W] = W'(8'h10 + i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_valid", o_valid0, 0);
        check("rst_data", o_data0, 0);
        check("rst_multi", o_multi0, 0);
        check("rst_nohit", o_nohit0, 0);
        check("rst_ready", o_ready0, 1);
        check("rst_valid_pri", o_valid1, 0);
        @(posedge clk);
        #1;

        // Single hit and latency
        send(6'b000100);
        @(negedge clk);
        check("lat_not_yet", o_valid0, 0);
        @(negedge clk);
        check("lat_valid", o_valid0, 1);
        drain();

        send(6'b100001);
        send(6'b000000);
        send(6'b001100);
        drain();

        // Backpressure: two accepted, third stalls
        i_ready = 1'b0;
        send(6'b000010);
        send(6'b000100);
        i_valid  = 1'b1;
        i_select = 6'b001000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready_low", o_ready0, 0);
            check("bp_valid_held", o_valid0, 1);
            check("bp_data_held", o_data0, 8'h11);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_reassert", o_ready0, 1);
        check("bp_out1_valid", o_valid0, 1);
        push_exp(6'b001000);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_out2_valid", o_valid0, 1);
        @(negedge clk);
        check("bp_out3_valid", o_valid0, 1);
        @(posedge clk);
        #1;
        drain();

        // Streaming
        base0 = pops0;
        base1 = pops1;
        for (int i = 0; i < 20; i++) begin
            s        = '0;
            s[$urandom_range(0, E-1)] = 1'b1;
            i_valid  = 1'b1;
            i_select = s;
            @(negedge clk);
            check("stream_ready", o_ready0, 1);
            push_exp(s);
            if (i >= 2) check("stream_valid", o_valid0, 1);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        drain();
        check("stream_count_or", pops0 - base0, 20);
        check("stream_count_pri", pops1 - base1, 20);

        // Reset mid-flight, with a request offered during reset
        i_ready = 1'b0;
        send(6'b000001);
        send(6'b000010);
        rst      = 1'b1;
        i_valid  = 1'b1;
        i_select = 6'b010000;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("mrst_valid", o_valid0, 0);
        check("mrst_ready", o_ready0, 1);
        check("mrst_valid_pri", o_valid1, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mrst_no_stale", o_valid0, 0);
        end
        @(posedge clk);
        #1;
        send(6'b010000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rggen_mux_pipe.md
# rggen_mux_pipe

Pipelined, flow-controlled one-hot AND-OR multiplexer for register-file read paths where ENTRIES × WIDTH is too large to close timing in one combinational level. Selects one of ENTRIES data words by a one-hot select vector. The reduction is split into a registered group stage and a registered final stage, with valid/ready handshaking on both sides. Adds multi-hit/no-hit detection and an optional lowest-index priority mode. Sits between register-block read-data collection and the bus response path.

## Interface
- WIDTH, 1: data word width in bits (≥1).
- ENTRIES, 2: number of selectable words (≥1).
- GROUP, 4: entries OR-reduced per stage-1 group (≥1). NG = ceil(ENTRIES/GROUP) groups; the last group may be partial.
- PRIORITY, 0: 0 = OR of all selected words; 1 = only the lowest-index set select bit is honoured.

- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request this cycle.
- i_select  input  ENTRIES  select vector; bit i chooses word i.
- i_data  input  WIDTH*ENTRIES  word i at [i*WIDTH +: WIDTH].
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  WIDTH  muxed result.
- o_multi_hit  output  1  more than one select bit was set in the request.
- o_no_hit  output  1  no select bit was set in the request.

## Operation
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- **Select conditioning (combinational):**
  - PRIORITY=1: effective select = i_select & (~i_select + 1), i.e. the lowest set bit only.
  - PRIORITY=0: effective select = i_select.
- **Stage 1 (S1), on input transfer, registers:**
  - Per group g: partial[g] = OR over entries in g of ({WIDTH{sel_eff[i]}} & word i).
  - Per group: any[g] = OR of raw i_select bits in g; multi[g] = more than one raw bit set in g.
  - Sets s1_valid.
- **Stage 2 (S2), on S1 advance, registers:**
  - o_data = OR of all partial[g].
  - o_no_hit = ~|any.
  - o_multi_hit = |multi || (more than one any[g] set).
  - Sets o_valid.
- Detection flags always reflect the raw i_select, including in PRIORITY=1.
- A zero select yields o_data = 0 with o_no_hit = 1. This is not an error path; the result is delivered normally.
- **Flow control:**
  - s2_adv = ~o_valid || i_ready.
  - s1_adv = s1_valid && s2_adv.
  - o_ready = ~s1_valid || s2_adv.
  - A stage that does not advance holds its contents. On output transfer with no S1 advance, o_valid clears.
- Data and flag registers load only on stage advance; valid bits are the only reset-critical state.
- Inputs need only be stable during the transfer cycle; the block captures them.

## Timing
- Reset: s1_valid = 0, o_valid = 0, o_data = 0, o_multi_hit = 0, o_no_hit = 0. o_ready = 1 in the first cycle after reset is released.
- i_rst asserted mid-operation drops all in-flight requests in the next cycle, with no output transfer. Reset dominates a simultaneous i_valid.
- Latency: request accepted at edge N gives o_valid high after edge N+1, when S2 is empty.
- Throughput: one result per cycle while i_ready = 1.
- With i_ready low the block holds at most 2 requests.
  - After both stages fill, o_ready = 0 combinationally from i_ready.
  - o_ready reasserts in the same cycle i_ready rises.
- o_ready depends combinationally on i_ready; no other input-to-output combinational path exists.
- o_valid, o_data, o_multi_hit and o_no_hit stay stable while o_valid && ~i_ready.
- Simultaneous input and output transfer with both stages full: S2 takes S1, S1 takes the new request, and no request is lost.
- ENTRIES=1 or GROUP ≥ ENTRIES: NG = 1 and latency is unchanged (still 2 register stages).

## Test plan
Benches use WIDTH=8, ENTRIES=6, GROUP=4, words 0x10..0x15, i_ready=1 unless stated.
- **Single hit:** select 6'b000100 accepted at edge N → o_valid after N+1, o_data = 0x12, both flags 0.
- **Multi-hit across groups:** select 6'b100001.
  - PRIORITY=0 → o_data = 0x15, o_multi_hit = 1.
  - PRIORITY=1 → o_data = 0x10, o_multi_hit = 1.
- **No hit:** select 0 → o_data = 0x00, o_no_hit = 1, o_valid asserted normally.
- **Backpressure:**
  - Stimulus: hold i_ready = 0 and offer selects for words 1, 2, 3 back-to-back.
  - Required: o_ready falls after 2 accepts, with o_data held at 0x11.
  - Release i_ready → outputs 0x11, 0x12, 0x13 on consecutive cycles, no loss or duplication.
- **Streaming:** 20 random one-hot requests with i_ready = 1 → 20 results in order, one per cycle, each matching the reference model.
- **Reset mid-flight:** two requests in flight, assert i_rst for one cycle → o_valid = 0 and o_ready = 1 afterwards, and no stale result appears.
